// File: rtl/hc_sr04_ranger.sv
// HC-SR04 ultrasonic ranger controller: self-refreshing measure strobe, 10 us trigger,
// echo high-time measurement in clock cycles with saturation and timeout.
`timescale 1ns/1ps
module hc_sr04_ranger #(
   parameter int REFRESH_CYCLES = 25_000_000,
   parameter int TRIG_CYCLES    = 1_000,
   parameter int TIMEOUT_CYCLES = 4_000_000,
   parameter int CNT_W          = 22
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             echo,
   output logic             measure,
   output logic             trig,
   output logic [1:0]       state,
   output logic             ready,
   output logic [CNT_W-1:0] distanceRAW
);

   localparam int RW = $clog2(REFRESH_CYCLES);
   localparam int TW = $clog2(TRIG_CYCLES + 1);
   localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_TRIG      = 2'd1,
      S_WAIT_ECHO = 2'd2,
      S_MEASURE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [RW-1:0]    rcnt;
   logic [TW-1:0]    tcnt;
   logic [OW-1:0]    tocnt;
   logic [CNT_W-1:0] ecnt;
   logic             echo_m, echo_s, echo_d;
   logic             seen_q, fell_q;
   logic             busy, fall, trig_done, timeout;
   logic             start, done, expire;

   // Refresher: strobe on the first enabled edge, then every REFRESH_CYCLES
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rcnt    <= '0;
         measure <= 1'b0;
      end else if (!en) begin
         rcnt    <= '0;
         measure <= 1'b0;
      end else begin
         measure <= (rcnt == '0);
         rcnt    <= (rcnt == RW'(REFRESH_CYCLES - 1)) ? '0 : rcnt + RW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign fall      = echo_d & ~echo_s;
   assign trig_done = (tcnt == TW'(TRIG_CYCLES - 1));
   assign timeout   = (tocnt == OW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // ready=1 means idle and distanceRAW holds the last valid result; a strobe
   // is accepted only while ready=1, anything else is dropped (no queueing).
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      done    = 1'b0;
      expire  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (measure) begin
               state_d = S_TRIG;
               start   = 1'b1;
            end
         end
         S_TRIG: begin
            if (trig_done) begin
               if (fell_q || (seen_q && fall)) done    = 1'b1;
               else if (echo_s)               state_d = S_MEASURE;
               else                           state_d = S_WAIT_ECHO;
            end
         end
         S_WAIT_ECHO: begin
            if (echo_s) state_d = S_MEASURE;
         end
         S_MEASURE: begin
            if (fall) done = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (busy && !done && timeout) expire = 1'b1;
      if (done || expire) state_d = S_IDLE;
   end

   assign trig  = (state_q == S_TRIG);
   assign ready = (state_q == S_IDLE);
   assign state = state_q;

   // Echo counting starts in TRIG since echo can rise before trig falls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt        <= '0;
         tocnt       <= '0;
         ecnt        <= '0;
         seen_q      <= 1'b0;
         fell_q      <= 1'b0;
         distanceRAW <= '0;
      end else begin
         if (start) begin
            tcnt   <= '0;
            tocnt  <= '0;
            ecnt   <= '0;
            seen_q <= 1'b0;
            fell_q <= 1'b0;
         end else if (busy) begin
            if (state_q == S_TRIG && !trig_done) tcnt <= tcnt + TW'(1);
            if (!timeout) tocnt <= tocnt + OW'(1);
            if (echo_s && !fell_q && ecnt != '1) ecnt <= ecnt + CNT_W'(1);
            if (echo_s) seen_q <= 1'b1;
            if (state_q == S_TRIG && seen_q && fall) fell_q <= 1'b1;
         end
         if (done)        distanceRAW <= ecnt;
         else if (expire) distanceRAW <= '1;
      end
   end

endmodule

// File: tb/tb_hc_sr04_ranger.sv
// Directed bench for hc_sr04_ranger with shortened refresh/trigger/timeout periods.
`timescale 1ns/1ps
module tb_hc_sr04_ranger;

   localparam int REFRESH = 3000;
   localparam int TRIGC   = 10;
   localparam int TMO     = 2000;
   localparam int CNT_W   = 22;
   localparam logic [CNT_W-1:0] ALL_ONES = 22'h3FFFFF;

   logic             clk;
   logic             rst;
   logic             en;
   logic             echo;
   logic             measure;
   logic             trig;
   logic [1:0]       state;
   logic             ready;
   logic [CNT_W-1:0] distanceRAW;

   int  checks;
   int  failures;
   time t_strobe;
   time t_trig;

   hc_sr04_ranger #(
      .REFRESH_CYCLES (REFRESH),
      .TRIG_CYCLES    (TRIGC),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .echo        (echo),
      .measure     (measure),
      .trig        (trig),
      .state       (state),
      .ready       (ready),
      .distanceRAW (distanceRAW)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic wait_measure(input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (measure === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wait_measure: no strobe within %0d cycles", limit);
      end
   endtask

   task automatic wait_ready(input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wait_ready: still busy after %0d cycles", limit);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b0;
      en   = 1'b0;
      echo = 1'b0;
      #100;
      @(negedge clk);
      checks += 5;
      if (trig !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b want 0", trig); end
      if (measure !== 1'b0) begin failures++; $display("FAIL reset_measure: got %b want 0", measure); end
      if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
      if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
      if (distanceRAW !== '0) begin failures++; $display("FAIL reset_dist: got %0d want 0", distanceRAW); end
      rst = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_strobe();
      int n;
      en = 1'b1;
      @(negedge clk);
      t_strobe = $time;
      checks++;
      if (measure !== 1'b1) begin failures++; $display("FAIL strobe_first: got %b want 1", measure); end
      @(negedge clk);
      t_trig = $time;
      checks += 3;
      if (measure !== 1'b0) begin failures++; $display("FAIL strobe_width: got %b want 0", measure); end
      if (state !== 2'd1) begin failures++; $display("FAIL strobe_state_trig: got %0d want 1", state); end
      if (trig !== 1'b1) begin failures++; $display("FAIL strobe_trig_high: got %b want 1", trig); end
      n = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (trig === 1'b1) n++;
         else break;
      end
      checks++;
      if (n != TRIGC) begin failures++; $display("FAIL trig_length: got %0d want %0d", n, TRIGC); end
   endtask

   task automatic test_timeout();
      longint busy;
      wait_ready(TMO + 100);
      busy = longint'(($time - t_trig) / 10);
      checks += 3;
      if (busy != TMO) begin failures++; $display("FAIL timeout_cycles: got %0d want %0d", busy, TMO); end
      if (distanceRAW !== ALL_ONES) begin failures++; $display("FAIL timeout_dist: got %h want %h", distanceRAW, ALL_ONES); end
      if (state !== 2'd0) begin failures++; $display("FAIL timeout_state: got %0d want 0", state); end
   endtask

   task automatic test_refresh_period();
      longint period;
      wait_measure(REFRESH);
      period = longint'(($time - t_strobe) / 10);
      checks++;
      if (period != REFRESH) begin failures++; $display("FAIL refresh_period: got %0d want %0d", period, REFRESH); end
   endtask

   // Called right at a strobe: echo rises while trig is still high
   task automatic test_echo_in_trig(input int width);
      @(negedge clk);
      echo = 1'b1;
      repeat (width) @(negedge clk);
      echo = 1'b0;
      wait_ready(TMO);
      checks++;
      if (distanceRAW < CNT_W'(width - 2) || distanceRAW > CNT_W'(width + 2)) begin
         failures++;
         $display("FAIL echo_in_trig_%0d: got %0d want %0d+/-2", width, distanceRAW, width);
      end
   endtask

   task automatic test_en_toggle();
      bit saw;
      wait_measure(REFRESH + 100);
      @(negedge clk);
      echo = 1'b1;
      saw  = 1'b0;
      for (int i = 0; i < 147; i++) begin
         @(negedge clk);
         if (i == 30) en = 1'b0;
         if (i == 35) en = 1'b1;
         if (measure === 1'b1) saw = 1'b1;
      end
      echo = 1'b0;
      wait_ready(TMO);
      checks += 2;
      if (saw !== 1'b1) begin failures++; $display("FAIL en_toggle_strobe: got %b want 1", saw); end
      if (distanceRAW < 22'd145 || distanceRAW > 22'd149) begin
         failures++;
         $display("FAIL en_toggle_dist: got %0d want 147+/-2", distanceRAW);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (state !== 2'd0) begin failures++; $display("FAIL strobe_not_queued: got state %0d want 0", state); end
   endtask

   task automatic test_echo_after_trig();
      wait_measure(REFRESH + 100);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (trig === 1'b0) break;
      end
      checks += 2;
      if (state !== 2'd2) begin failures++; $display("FAIL wait_echo_state: got %0d want 2", state); end
      if (distanceRAW < 22'd145 || distanceRAW > 22'd149) begin
         failures++;
         $display("FAIL dist_hold: got %0d want 147+/-2", distanceRAW);
      end
      repeat (5) @(negedge clk);
      echo = 1'b1;
      for (int i = 0; i < 294; i++) begin
         @(negedge clk);
         if (i == 3) begin
            checks++;
            if (state !== 2'd3) begin failures++; $display("FAIL measure_state: got %0d want 3", state); end
         end
      end
      echo = 1'b0;
      wait_ready(TMO);
      checks++;
      if (distanceRAW < 22'd292 || distanceRAW > 22'd296) begin
         failures++;
         $display("FAIL echo_after_trig: got %0d want 294+/-2", distanceRAW);
      end
   endtask

   task automatic test_short_echo_in_trig();
      time    t0;
      longint busy;
      wait_measure(REFRESH + 100);
      @(negedge clk);
      t0   = $time;
      echo = 1'b1;
      repeat (3) @(negedge clk);
      echo = 1'b0;
      wait_ready(100);
      busy = longint'(($time - t0) / 10);
      checks += 2;
      if (busy != TRIGC) begin failures++; $display("FAIL short_echo_busy: got %0d want %0d", busy, TRIGC); end
      if (distanceRAW < 22'd1 || distanceRAW > 22'd5) begin
         failures++;
         $display("FAIL short_echo_dist: got %0d want 3+/-2", distanceRAW);
      end
   endtask

   task automatic test_reset_mid();
      wait_measure(REFRESH + 100);
      @(negedge clk);
      echo = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      checks += 5;
      if (trig !== 1'b0) begin failures++; $display("FAIL mid_reset_trig: got %b want 0", trig); end
      if (state !== 2'd0) begin failures++; $display("FAIL mid_reset_state: got %0d want 0", state); end
      if (ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready: got %b want 1", ready); end
      if (measure !== 1'b0) begin failures++; $display("FAIL mid_reset_measure: got %b want 0", measure); end
      if (distanceRAW !== '0) begin failures++; $display("FAIL mid_reset_dist: got %0d want 0", distanceRAW); end
      #20;
      @(negedge clk);
      echo = 1'b0;
      en   = 1'b0;
      rst  = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_strobe();
      test_timeout();
      test_refresh_period();
      test_echo_in_trig(100);
      test_en_toggle();
      test_echo_after_trig();
      test_short_echo_in_trig();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
